// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - start/busy/done handshake and result bundle between datapath and divider
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               sign_en;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [2*WIDTH-1:0] z_result;

    modport master (
        output start, sign_en, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, z_result
    );

    modport slave (
        input  start, sign_en, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, z_result
    );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 non-restoring WIDTH-bit divider, {remainder, quotient} result for Z capture
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        clr,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_next;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg, d_reg;
    logic [CW-1:0]    count;
    logic             q_neg, r_neg, zero_op;
    logic             busy_reg, done_reg, busy_next, done_next;
    logic             dz_reg;
    logic [WIDTH-1:0] quot_reg, rem_reg;

    logic [WIDTH:0]   d_ext, p_shift, p_step;
    logic [WIDTH-1:0] p_fix, q_out, r_out, dividend_abs, divisor_abs;
    logic             divisor_zero;

    assign divisor_zero = (bus.divisor == '0);
    assign dividend_abs = (bus.sign_en && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign divisor_abs  = (bus.sign_en && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // One non-restoring step: the sign of the old P picks subtract or add.
    assign d_ext   = {1'b0, d_reg};
    assign p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign p_step  = p_reg[WIDTH] ? p_shift + d_ext : p_shift - d_ext;
    assign p_fix   = p_reg[WIDTH] ? p_reg[WIDTH-1:0] + d_reg : p_reg[WIDTH-1:0];
    assign q_out   = q_neg ? -q_reg : q_reg;
    assign r_out   = r_neg ? -p_fix : p_fix;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = divisor_zero ? FIX : RUN;
            RUN:     if (count == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered handshake: busy drops on the same edge that raises done.
    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = (state == FIX);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            p_reg    <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            count    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_op  <= 1'b0;
            dz_reg   <= 1'b0;
            quot_reg <= '0;
            rem_reg  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    q_neg   <= bus.sign_en & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    r_neg   <= bus.sign_en & bus.dividend[WIDTH-1];
                    p_reg   <= '0;
                    count   <= CW'(WIDTH);
                    zero_op <= divisor_zero;
                    // Zero divisor keeps the raw dividend; it becomes the remainder.
                    q_reg   <= divisor_zero ? bus.dividend : dividend_abs;
                    d_reg   <= divisor_abs;
                end
                RUN: begin
                    p_reg <= p_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~p_step[WIDTH]};
                    count <= count - 1'b1;
                end
                FIX: begin
                    if (zero_op) begin
                        quot_reg <= '1;
                        rem_reg  <= q_reg;
                        dz_reg   <= 1'b1;
                    end else begin
                        quot_reg <= q_out;
                        rem_reg  <= r_out;
                        dz_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dz_reg;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.z_result    = {rem_reg, quot_reg};
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector table, handshake corner sequences and random model check for div_unit
module tb_div_unit;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) dif();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .clr(clr), .bus(dif));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge with operands scrambled.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        dif.start    = 1'b1;
        dif.sign_en  = s;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.sign_en  = ~s;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
    endtask

    // Edges counted from the accept edge (1) through the edge raising done.
    task automatic wait_done(output int n);
        n = 1;
        while (dif.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int          n;
    int          pulses;
    logic        overlap;
    logic [31:0] cap_q, cap_r;
    logic [31:0] eq, er;
    logic        edz;
    logic [31:0] ra, rb;
    logic        rs;
    longint      la, lb, lq, lr;

    initial begin
        vecs[0]  = '{1'b1, 32'd10,        32'd2,         32'h00000005, 32'h00000000, 1'b0, 34};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
        vecs[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001, 1'b0, 34};
        vecs[3]  = '{1'b1, 32'd18,        32'd0,         32'hFFFFFFFF, 32'h00000012, 1'b1, 2};
        vecs[4]  = '{1'b1, 32'd10,        32'd2,         32'h00000005, 32'h00000000, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000, 1'b0, 34};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'h00000010,  32'h0FFFFFFF, 32'h0000000F, 1'b0, 34};
        vecs[7]  = '{1'b0, 32'd100,       32'd7,         32'd14,       32'd2,        1'b0, 34};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,       32'hFFFFFFFE, 1'b0, 34};
        vecs[9]  = '{1'b0, 32'd0,         32'd5,         32'd0,        32'd0,        1'b0, 34};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,        32'd0,        1'b0, 34};
        vecs[11] = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF, 32'd5,        1'b1, 2};
        vecs[12] = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2};
        vecs[13] = '{1'b0, 32'h80000000,  32'd3,         32'h2AAAAAAA, 32'd2,        1'b0, 34};

        clr          = 1'b0;
        dif.start    = 1'b0;
        dif.sign_en  = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, dif.busy}, 64'd0);
        check("reset_done", {63'd0, dif.done}, 64'd0);
        check("reset_dz", {63'd0, dif.div_by_zero}, 64'd0);
        check("reset_z", dif.z_result, 64'd0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_busy", i), {63'd0, dif.busy}, 64'd1);
            wait_done(n);
            check($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].lat));
            check($sformatf("v%0d_busy_at_done", i), {63'd0, dif.busy}, 64'd0);
            check($sformatf("v%0d_quotient", i), {32'd0, dif.quotient}, {32'd0, vecs[i].q});
            check($sformatf("v%0d_remainder", i), {32'd0, dif.remainder}, {32'd0, vecs[i].r});
            check($sformatf("v%0d_z", i), dif.z_result, {vecs[i].r, vecs[i].q});
            check($sformatf("v%0d_dz", i), {63'd0, dif.div_by_zero}, {63'd0, vecs[i].dz});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {63'd0, dif.done}, 64'd0);
            check($sformatf("v%0d_hold_q", i), {32'd0, dif.quotient}, {32'd0, vecs[i].q});
        end

        // start while busy is ignored
        launch(1'b0, 32'd100, 32'd7);
        repeat (8) begin @(posedge clk); #1; end
        dif.start = 1'b1; dif.sign_en = 1'b0; dif.dividend = 32'd50; dif.divisor = 32'd5;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        pulses = 0; overlap = 1'b0; cap_q = '0; cap_r = '0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (dif.done && dif.busy) overlap = 1'b1;
            if (dif.done) begin pulses++; cap_q = dif.quotient; cap_r = dif.remainder; end
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_q", {32'd0, cap_q}, 64'd14);
        check("ignore_r", {32'd0, cap_r}, 64'd2);
        check("ignore_overlap", {63'd0, overlap}, 64'd0);

        // clr mid-run
        launch(1'b0, 32'd1000, 32'd3);
        repeat (14) begin @(posedge clk); #1; end
        clr = 1'b0;
        #1;
        check("clr_busy", {63'd0, dif.busy}, 64'd0);
        check("clr_done", {63'd0, dif.done}, 64'd0);
        check("clr_dz", {63'd0, dif.div_by_zero}, 64'd0);
        check("clr_z", dif.z_result, 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (dif.done) pulses++;
        end
        check("clr_no_done", 64'(pulses), 64'd0);

        // back-to-back accept in the done cycle
        launch(1'b0, 32'd100, 32'd7);
        wait_done(n);
        check("b2b_first_latency", 64'(n), 64'd34);
        launch(1'b1, 32'hFFFFFF9C, 32'd7);
        check("b2b_hold_q", {32'd0, dif.quotient}, 64'd14);
        wait_done(n);
        check("b2b_second_latency", 64'(n), 64'd34);
        check("b2b_second_q", {32'd0, dif.quotient}, {32'd0, 32'hFFFFFFF2});
        check("b2b_second_r", {32'd0, dif.remainder}, {32'd0, 32'hFFFFFFFE});

        // random operands against a 64-bit reference model
        for (int i = 0; i < 1000; i++) begin
            rs = i[0];
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 2) rb = $urandom_range(0, 15);
            if (i % 8 == 3) rb = -$urandom_range(1, 9);
            if (i % 8 == 5) ra = $urandom_range(0, 100);
            if (i % 50 == 7) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (rb == 32'd0) begin
                eq = '1; er = ra; edz = 1'b1;
            end else begin
                edz = 1'b0;
                if (rs) begin
                    la = longint'($signed(ra));
                    lb = longint'($signed(rb));
                end else begin
                    la = longint'({32'd0, ra});
                    lb = longint'({32'd0, rb});
                end
                lq = la / lb;
                lr = la % lb;
                eq = lq[31:0];
                er = lr[31:0];
            end
            launch(rs, ra, rb);
            wait_done(n);
            check($sformatf("rnd%0d_q a=%0h b=%0h s=%0d", i, ra, rb, rs), {32'd0, dif.quotient}, {32'd0, eq});
            check($sformatf("rnd%0d_r", i), {32'd0, dif.remainder}, {32'd0, er});
            check($sformatf("rnd%0d_dz", i), {63'd0, dif.div_by_zero}, {63'd0, edz});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the datapath's ALU divide operation. The datapath launches it with the divide-select operands (Y-register value as dividend, bus value as divisor). It returns a 64-bit result with the remainder in the upper half and the quotient in the lower half. The datapath captures that result into Z, then moves ZHI into HI and ZLO into LO. The divider is a radix-2 non-restoring engine with a start/busy/done handshake, so the datapath control FSM must hold in its Z-capture step until done is high.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  in  1  system clock, all state updates on rising edge.
- clr  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- sign_en  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result valid in that cycle and held afterwards.
- div_by_zero  out  1  registered flag for the last completed operation.
- quotient  out  WIDTH  last quotient (feeds ZLO).
- remainder  out  WIDTH  last remainder (feeds ZHI).
- z_result  out  2*WIDTH  {remainder, quotient}.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1, divisor≠0:
  - latch |dividend| and |divisor| (absolute values only when sign_en=1);
  - record quotient sign = sign(dividend) XOR sign(divisor), and remainder sign = sign(dividend);
  - clear the partial remainder P (WIDTH+1 bits); count = WIDTH;
  - next state RUN.
- IDLE, start=1, divisor=0: latch the dividend; next state FIX with the zero flag set; no iterations run.
- RUN, each cycle (one non-restoring step):
  - shift {P,Q} left 1;
  - P = P − D if P ≥ 0, else P = P + D;
  - new Q LSB = ~P sign bit;
  - count decrements; at count=1 the step executes and the next state is FIX.
- FIX, normal path:
  - if P < 0, P = P + D;
  - negate Q if the quotient sign is negative, and negate P if the remainder sign is negative;
  - write quotient/remainder registers; done=1; div_by_zero=0; next state IDLE.
- FIX, zero path: quotient = all ones, remainder = latched dividend, div_by_zero=1, done=1.
- Quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
- Signed overflow: 0x80000000 / −1 gives quotient 0x80000000, remainder 0 (natural wrap, no flag).
- start while busy: ignored, no queueing.
- Result registers change only in FIX; they hold between operations.

## Timing
- Reset (clr=0): state IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, z_result=0; internal P, Q, D, count cleared.
- Accept edge E0 (IDLE, start=1).
  - busy=1 from E0 through the FIX cycle.
  - Normal path: done=1 in the cycle after edge E0+WIDTH+1, i.e. 34 cycles after acceptance for WIDTH=32.
  - Divide by zero: done=1 in the cycle after edge E0+1, i.e. 2 cycles.
- done and busy are registered and never high together; busy falls on the same edge done rises.
- start=1 in the done cycle is accepted (state is IDLE); the new result overwrites only at its own FIX.
- clr asserted mid-RUN: immediate return to IDLE, outputs zero, no done pulse.
- Operands may change after E0 without affecting the operation in flight.

## Test plan
- After reset, signed 10 / 2 → done after 34 cycles; quotient 0x00000005, remainder 0, z_result 0x00000000_00000005, div_by_zero 0.
- Signed −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); then 7 / −2 → quotient −3, remainder 1.
- 18 / 0 → done after 2 cycles; div_by_zero=1, quotient 0xFFFFFFFF, remainder 0x00000012; next valid divide clears the flag.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 0x10 → quotient 0x0FFFFFFF, remainder 0xF.
- start pulsed at cycle 10 of a running 100/7 → ignored; result quotient 14, remainder 2, single done pulse.
- clr low at cycle 15 of a run → busy=0, all outputs 0, no done. Then start asserted during a done cycle → back-to-back accept, second done 34 cycles later.
- Randomized 1000 operand pairs, both sign_en values → compare against reference model: quotient×divisor + remainder = dividend, plus the sign rules above.
